// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and the FSM state type for the iterative InvMixColumns block.
// Optional macro INV_MIX_FWD_EN adds the forward MixColumns multipliers.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
   endfunction

   function automatic logic [7:0] gmul09(input logic [7:0] x);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(x)));
      return x8 ^ x;
   endfunction

   function automatic logic [7:0] gmul0b(input logic [7:0] x);
      logic [7:0] x2;
      logic [7:0] x8;
      x2 = xtime(x);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ x;
   endfunction

   function automatic logic [7:0] gmul0d(input logic [7:0] x);
      logic [7:0] x4;
      logic [7:0] x8;
      x4 = xtime(xtime(x));
      x8 = xtime(x4);
      return x8 ^ x4 ^ x;
   endfunction

   function automatic logic [7:0] gmul0e(input logic [7:0] x);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

`ifdef INV_MIX_FWD_EN
   function automatic logic [7:0] gmul02(input logic [7:0] x);
      return xtime(x);
   endfunction

   function automatic logic [7:0] gmul03(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction
`endif

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for inv_mix_columns_iter: input side (data/in_valid/in_ready) and result side.
// With INV_MIX_FWD_EN defined the bundle also carries mode_fwd.
interface inv_mix_columns_iter_if;
   logic [127:0] data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] inv_mixcolumns;
   logic         out_valid;
   logic         out_ready;
`ifdef INV_MIX_FWD_EN
   logic         mode_fwd;

   modport master (
      output data, in_valid, out_ready, mode_fwd,
      input  in_ready, inv_mixcolumns, out_valid
   );
   modport slave (
      input  data, in_valid, out_ready, mode_fwd,
      output in_ready, inv_mixcolumns, out_valid
   );
`else
   modport master (
      output data, in_valid, out_ready,
      input  in_ready, inv_mixcolumns, out_valid
   );
   modport slave (
      input  data, in_valid, out_ready,
      output in_ready, inv_mixcolumns, out_valid
   );
`endif
endinterface

// File: rtl/inv_mix_column_word.sv
// Combinational single-column (Inv)MixColumns; byte 0 is the MSB of the word.
// With INV_MIX_FWD_EN defined, mode_fwd=1 selects the forward matrix.
module inv_mix_column_word
   import aes_pkg::*;
(
   input  logic [31:0] word,
`ifdef INV_MIX_FWD_EN
   input  logic        mode_fwd,
`endif
   output logic [31:0] result
);

   logic [7:0] col_bytes [4];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_row
         logic [7:0] inv_byte;
         assign col_bytes[gi] = word[31-8*gi -: 8];
         // Row gi uses the circulant matrix rotated right by gi positions.
         assign inv_byte = gmul0e(col_bytes[gi])         ^ gmul0b(col_bytes[(gi+1)%4]) ^
                           gmul0d(col_bytes[(gi+2)%4])   ^ gmul09(col_bytes[(gi+3)%4]);
`ifdef INV_MIX_FWD_EN
         logic [7:0] fwd_byte;
         assign fwd_byte = gmul02(col_bytes[gi])       ^ gmul03(col_bytes[(gi+1)%4]) ^
                           col_bytes[(gi+2)%4]         ^ col_bytes[(gi+3)%4];
         assign result[31-8*gi -: 8] = mode_fwd ? fwd_byte : inv_byte;
`else
         assign result[31-8*gi -: 8] = inv_byte;
`endif
      end
   endgenerate

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per clock through a shared column unit, latency 4.
// Optional macro INV_MIX_FWD_EN adds mode_fwd (forward MixColumns when 1).
module inv_mix_columns_iter
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   inv_mix_columns_iter_if.slave bus
);

   state_t       state_reg;
   logic [1:0]   col_reg;
   logic [127:0] data_reg;
   logic [31:0]  result_words_reg [4];
   logic         out_valid_reg;
`ifdef INV_MIX_FWD_EN
   logic         mode_reg;
`endif

   logic [31:0]  data_words [4];
   logic [31:0]  col_word;
   logic [31:0]  col_result;
   logic [127:0] result_flat;
   logic         accept;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_col
         assign data_words[gi]               = data_reg[127-32*gi -: 32];
         assign result_flat[127-32*gi -: 32] = result_words_reg[gi];
      end
   endgenerate

   assign col_word = data_words[col_reg];

   inv_mix_column_word u_word (
      .word     (col_word),
`ifdef INV_MIX_FWD_EN
      .mode_fwd (mode_reg),
`endif
      .result   (col_result)
   );

   // Retiring a result and accepting the next block can share one edge.
   assign bus.in_ready       = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
   assign accept             = bus.in_valid && bus.in_ready;
   assign bus.out_valid      = out_valid_reg;
   assign bus.inv_mixcolumns = result_flat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         col_reg       <= 2'd0;
         data_reg      <= '0;
         out_valid_reg <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            result_words_reg[i] <= '0;
         end
`ifdef INV_MIX_FWD_EN
         mode_reg      <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: ;
            BUSY: begin
               result_words_reg[col_reg] <= col_result;
               col_reg                   <= col_reg + 2'd1;
               if (col_reg == 2'd3) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready && !bus.in_valid) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
            end
         endcase

         // accept can only be true in IDLE or DONE, so it never collides with BUSY updates.
         if (accept) begin
            data_reg      <= bus.data;
            col_reg       <= 2'd0;
            state_reg     <= BUSY;
            out_valid_reg <= 1'b0;
`ifdef INV_MIX_FWD_EN
            mode_reg      <= bus.mode_fwd;
`endif
         end
      end
   end

endmodule
